// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO feeding an 8N1-style UART serializer with
// optional parity, 1 or 2 stop bits and RTS flow control checked at frame start.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for a queued word and USB_RTS low
// ST_START  | start bit (0) for OVERSAMPLE cycles
// ST_DATA   | DATA_BITS payload bits, LSB first
// ST_PARITY | one parity bit (only reached when PARITY != 0)
// ST_STOP   | STOP_BITS stop bits (1); last cycle may chain into ST_START
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 uart_sampling_clk,
    input  logic                                 rst_n,
    input  logic [DATA_BITS-1:0]                 tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    input  logic                                 USB_RTS,
    output logic                                 USB_TX,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    state_t               r_state;
    logic [SAMP_W-1:0]    r_sample;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    state_t               w_state_nx;
    logic [SAMP_W-1:0]    w_sample_nx;
    logic [BIT_W-1:0]     w_bit_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_par_nx;
    logic                 w_tx_nx;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_can_start;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push      = tx_valid && !w_full;
    assign w_can_start = (r_count != '0) && !USB_RTS;
    assign w_bit_end   = (r_sample == SAMP_W'(OVERSAMPLE - 1));
    assign w_head      = r_mem[r_rd_ptr];

    assign tx_ready   = !w_full;
    assign USB_TX     = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = r_count;

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge uart_sampling_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register; the line level is registered alongside the state.
    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sample <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_sample <= w_sample_nx;
            r_bit    <= w_bit_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_tx     <= w_tx_nx;
        end
    end

    // Next-state logic; w_tx_nx is the level of the bit the next state carries.
    always_comb begin
        w_state_nx  = r_state;
        w_sample_nx = w_bit_end ? '0 : r_sample + 1'b1;
        w_bit_nx    = r_bit;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_tx_nx     = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sample_nx = '0;
                w_tx_nx     = 1'b1;
                if (w_can_start) begin
                    w_pop       = 1'b1;
                    w_shift_nx  = w_head;
                    w_par_nx    = (^w_head) ^ (PARITY == 1);
                    w_bit_nx    = '0;
                    w_state_nx  = ST_START;
                    w_tx_nx     = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                    w_bit_nx   = '0;
                    w_tx_nx    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                        w_bit_nx = '0;
                        if (PARITY != 0) begin
                            w_state_nx = ST_PARITY;
                            w_tx_nx    = r_par;
                        end else begin
                            w_state_nx = ST_STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_bit_nx   = r_bit + 1'b1;
                        w_shift_nx = r_shift >> 1;
                        w_tx_nx    = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = ST_STOP;
                    w_bit_nx   = '0;
                    w_tx_nx    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == BIT_W'(STOP_BITS - 1)) begin
                        // Final stop cycle: the only point besides IDLE where RTS is honoured.
                        w_bit_nx = '0;
                        if (w_can_start) begin
                            w_pop      = 1'b1;
                            w_shift_nx = w_head;
                            w_par_nx   = (^w_head) ^ (PARITY == 1);
                            w_state_nx = ST_START;
                            w_tx_nx    = 1'b0;
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                        w_tx_nx  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_sample_nx = '0;
                w_tx_nx     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four instances (default, even parity, odd parity, 5 data + 2 stop)
// sharing one clock and reset; expected line levels are hand-built frame constants.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data    [4];
    logic       tx_valid   [4];
    logic       usb_rts    [4];
    logic       usb_tx     [4];
    logic       busy       [4];
    logic       tx_ready   [4];
    logic [2:0] fifo_count [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_frame [4];
    int          exp_len   [4];
    logic [7:0]  words     [5];

    always #5 clk = ~clk;

    uart_tx_fifo u_dut0 (
        .uart_sampling_clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .USB_RTS(usb_rts[0]), .USB_TX(usb_tx[0]), .busy(busy[0]),
        .fifo_count(fifo_count[0]));

    uart_tx_fifo #(.PARITY(2)) u_dut_even (
        .uart_sampling_clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .USB_RTS(usb_rts[1]), .USB_TX(usb_tx[1]), .busy(busy[1]),
        .fifo_count(fifo_count[1]));

    uart_tx_fifo #(.PARITY(1)) u_dut_odd (
        .uart_sampling_clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .USB_RTS(usb_rts[2]), .USB_TX(usb_tx[2]), .busy(busy[2]),
        .fifo_count(fifo_count[2]));

    uart_tx_fifo #(.DATA_BITS(5), .STOP_BITS(2)) u_dut_s2 (
        .uart_sampling_clk(clk), .rst_n(rst_n), .tx_data(tx_data[3][4:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .USB_RTS(usb_rts[3]), .USB_TX(usb_tx[3]), .busy(busy[3]),
        .fifo_count(fifo_count[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One default-instance frame of 160 cycles; optionally raises RTS at cycle rts_at.
    task automatic frame0(input logic [7:0] d, input logic [2:0] cnt0, input int rts_at,
                          input string tag);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tx_valid[0] = 1'b0;
                chk({tag, " count_at_start"}, 32'(fifo_count[0]), 32'(cnt0));
            end
            chk({tag, " tx"}, 32'(usb_tx[0]), 32'(f[c/16]));
            chk({tag, " busy"}, 32'(busy[0]), 32'd1);
            if (c == rts_at) usb_rts[0] = 1'b1;
        end
    endtask

    task automatic idle0(input string tag, input logic [2:0] cnt);
        chk({tag, " idle_tx"}, 32'(usb_tx[0]), 32'd1);
        chk({tag, " idle_busy"}, 32'(busy[0]), 32'd0);
        chk({tag, " idle_count"}, 32'(fifo_count[0]), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
            usb_rts[i]  = 1'b0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset tx", 32'(usb_tx[i]), 32'd1);
            chk("reset busy", 32'(busy[i]), 32'd0);
            chk("reset count", 32'(fifo_count[i]), 32'd0);
            chk("reset ready", 32'(tx_ready[i]), 32'd1);
        end

        // Release reset and write on the very first edge; one frame per instance
        exp_frame[0] = {1'b0, 1'b1, 8'hAA, 1'b0};
        exp_frame[1] = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_frame[2] = {1'b1, 1'b0, 8'h07, 1'b0};
        exp_frame[3] = {3'b000, 2'b11, 5'h1F, 1'b0};
        exp_len[0] = 10; exp_len[1] = 11; exp_len[2] = 11; exp_len[3] = 8;
        rst_n = 1'b1;
        tx_data[0] = 8'hAA; tx_data[1] = 8'h07; tx_data[2] = 8'h07; tx_data[3] = 8'h1F;
        for (int i = 0; i < 4; i++) tx_valid[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_valid[i] = 1'b0;
            chk("accept count", 32'(fifo_count[i]), 32'd1);
            chk("accept tx_still_idle", 32'(usb_tx[i]), 32'd1);
        end
        for (int c = 0; c < 177; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (c < exp_len[i] * 16) begin
                    chk($sformatf("frame%0d tx c%0d", i, c), 32'(usb_tx[i]), 32'(exp_frame[i][c/16]));
                    chk($sformatf("frame%0d busy c%0d", i, c), 32'(busy[i]), 32'd1);
                end else if (c == exp_len[i] * 16) begin
                    chk($sformatf("frame%0d end_tx", i), 32'(usb_tx[i]), 32'd1);
                    chk($sformatf("frame%0d end_busy", i), 32'(busy[i]), 32'd0);
                    chk($sformatf("frame%0d end_count", i), 32'(fifo_count[i]), 32'd0);
                end
            end
        end

        // RTS held: five writes, four accepted, line stays idle
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        usb_rts[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fill ready k%0d", k), 32'(tx_ready[0]), (k < 4) ? 32'd1 : 32'd0);
            tx_data[0]  = words[k];
            tx_valid[0] = 1'b1;
            @(negedge clk);
        end
        tx_valid[0] = 1'b0;
        chk("full ready", 32'(tx_ready[0]), 32'd0);
        idle0("full", 3'd4);
        repeat (20) @(negedge clk);
        idle0("rts_hold", 3'd4);

        // Drop RTS: four back-to-back frames, no gap, count falls at each start
        usb_rts[0] = 1'b0;
        frame0(8'h11, 3'd3, -1, "b2b0");
        frame0(8'h22, 3'd2, -1, "b2b1");
        frame0(8'h33, 3'd1, -1, "b2b2");
        frame0(8'h44, 3'd0, -1, "b2b3");
        @(negedge clk);
        idle0("b2b_done", 3'd0);

        // RTS raised at data bit 3 with two words queued
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_data[0]  = 8'h5A;
        frame0(8'h3C, 3'd1, 64, "rts_mid");
        repeat (40) @(negedge clk);
        idle0("rts_mid_hold", 3'd1);
        usb_rts[0] = 1'b0;
        frame0(8'h5A, 3'd0, -1, "rts_resume");
        @(negedge clk);
        idle0("rts_resume_done", 3'd0);

        // Reset mid-frame with three words queued
        words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24; words[3] = 8'h18;
        for (int k = 0; k < 4; k++) begin
            tx_data[0]  = words[k];
            tx_valid[0] = 1'b1;
            @(negedge clk);
        end
        tx_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst busy", 32'(busy[0]), 32'd1);
        chk("pre_rst count", 32'(fifo_count[0]), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst tx", 32'(usb_tx[0]), 32'd1);
        chk("mid_rst busy", 32'(busy[0]), 32'd0);
        chk("mid_rst count", 32'(fifo_count[0]), 32'd0);
        chk("mid_rst ready", 32'(tx_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("post_rst tx", 32'(usb_tx[0]), 32'd1);
            chk("post_rst busy", 32'(busy[0]), 32'd0);
        end
        chk("post_rst count", 32'(fifo_count[0]), 32'd0);

        // Fresh write after the aborted frame
        tx_data[0]  = 8'h0F;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        frame0(8'h0F, 3'd0, -1, "post_rst_frame");
        @(negedge clk);
        idle0("post_rst_done", 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-002 Parameter: OVERSAMPLE, default 16, uart_sampling_clk cycles per serial bit; legal range >= 2.
REQ-003 Parameter: PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter: STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter: FIFO_DEPTH, default 4, transmit FIFO entries; must be a power of 2, >= 2.
REQ-006 Port: uart_sampling_clk  input  1  sole clock, rising edge.
REQ-007 Port: rst_n  input  1  asynchronous active-low reset.
REQ-008 Port: tx_data  input  DATA_BITS  word to enqueue.
REQ-009 Port: tx_valid  input  1  tx_data is valid this cycle.
REQ-010 Port: tx_ready  output  1  FIFO can accept a word (not full).
REQ-011 Port: USB_RTS  input  1  flow control; high means the host holds off new frames.
REQ-012 Port: USB_TX  output  1  registered serial line; idle high.
REQ-013 Port: busy  output  1  a frame is on the line (state other than IDLE).
REQ-014 Port: fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-015 A word SHALL be enqueued on a rising edge where tx_valid && tx_ready; tx_valid with tx_ready low SHALL be ignored with no state change.
REQ-016 tx_ready SHALL equal (fifo_count != FIFO_DEPTH); a pop in the same cycle SHALL NOT make a full FIFO accept a push.
REQ-017 Push and pop in the same cycle on a non-full, non-empty FIFO SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE, with fifo_count != 0 and USB_RTS low, the next edge SHALL pop the head word into the shift register, enter START, and drive USB_TX low.
REQ-020 Each state bit SHALL last exactly OVERSAMPLE cycles, timed by a sample counter that counts 0..OVERSAMPLE-1 and wraps.
REQ-021 START SHALL drive 0; DATA SHALL drive DATA_BITS bits LSB first; PARITY, when enabled, SHALL drive one bit; STOP SHALL drive 1 for STOP_BITS*OVERSAMPLE cycles.
REQ-022 The parity bit SHALL make the count of ones over data+parity odd (PARITY=1) or even (PARITY=2); the PARITY state SHALL be skipped when PARITY=0.
REQ-023 USB_RTS SHALL be sampled only at frame start (IDLE, and the final STOP cycle); a frame in progress SHALL complete regardless of USB_RTS.
REQ-024 On the final STOP cycle, with the FIFO non-empty and USB_RTS low, the FSM SHALL go directly to START, popping the next word with no idle cycle between frames; otherwise it SHALL go to IDLE.
REQ-025 Total frame length SHALL be (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * OVERSAMPLE cycles.
REQ-026 busy SHALL be high for every cycle USB_TX carries a frame bit and low in IDLE.
REQ-027 Latency: a word accepted at edge N into an empty FIFO while IDLE with USB_RTS low SHALL produce USB_TX low from edge N+1.

Reset
REQ-028 While rst_n is low, asynchronously: state=IDLE, USB_TX=1, busy=0, fifo_count=0, tx_ready=1, FIFO pointers, sample and bit counters = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (USB_TX=1) and discard all FIFO contents; no partial frame SHALL resume after release.
REQ-030 The first enqueue SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Defaults, write 0xAA, USB_RTS=0 -> USB_TX: 0 for 16 cycles, then 0,1,0,1,0,1,0,1 for 16 cycles each, then 1 for 16 cycles; busy high for 160 cycles.
REQ-032 PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0; frame length 176 cycles.
REQ-033 USB_RTS=1, write 5 words back-to-back -> 4 accepted, tx_ready low after the 4th, fifo_count=4, USB_TX stays 1; drop USB_RTS -> 4 contiguous frames, no idle gap, fifo_count decrements at each START.
REQ-034 Raise USB_RTS at DATA bit 3 with 2 words queued -> current frame completes, USB_TX stays 1 afterwards, fifo_count=1 until USB_RTS falls.
REQ-035 Pulse rst_n low during DATA with 3 words queued -> USB_TX=1 and fifo_count=0 immediately; after release no frame starts without a new write.
REQ-036 STOP_BITS=2, DATA_BITS=5, write 0x1F -> start 16 cycles, five 1 bits, stop high 32 cycles, total 128 cycles.
